// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the 8-bit CPU front end.
// Holds opcodes, ALU codes, instruction field positions and default widths.
package cpu_pkg;

    // Default datapath geometry
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_REG_AW  = 3;
    localparam int DEF_INSTR_W = 32;

    // Instruction field positions
    localparam int OPC_W    = 8;
    localparam int OPC_LSB  = 24;
    localparam int DEST_LSB = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;
    localparam int IMM_LSB  = 0;

    // Opcodes
    localparam logic [OPC_W-1:0] OP_LOADI = 8'h00;
    localparam logic [OPC_W-1:0] OP_MOV   = 8'h01;
    localparam logic [OPC_W-1:0] OP_ADD   = 8'h02;
    localparam logic [OPC_W-1:0] OP_SUB   = 8'h03;
    localparam logic [OPC_W-1:0] OP_AND   = 8'h04;
    localparam logic [OPC_W-1:0] OP_OR    = 8'h05;

    // ALU operation codes
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Per-opcode control bundle
    typedef struct packed {
        logic [2:0] alu_op;
        logic       use_imm;
        logic       negate;
        logic       writes;
        logic       uses_src1;
        logic       uses_src2;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: pure combinational opcode -> control bundle lookup.
// Ports: opcode (in, OPC_W), dec (out, dec_t control bundle).
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    always_comb begin
        dec = '0;
        unique case (opcode)
            OP_LOADI: begin
                dec.alu_op  = ALU_FWD;
                dec.use_imm = 1'b1;
                dec.writes  = 1'b1;
            end
            OP_MOV: begin
                dec.alu_op    = ALU_FWD;
                dec.writes    = 1'b1;
                dec.uses_src2 = 1'b1;
            end
            OP_ADD: begin
                dec.alu_op    = ALU_ADD;
                dec.writes    = 1'b1;
                dec.uses_src1 = 1'b1;
                dec.uses_src2 = 1'b1;
            end
            OP_SUB: begin
                dec.alu_op    = ALU_ADD;
                dec.negate    = 1'b1;
                dec.writes    = 1'b1;
                dec.uses_src1 = 1'b1;
                dec.uses_src2 = 1'b1;
            end
            OP_AND: begin
                dec.alu_op    = ALU_AND;
                dec.writes    = 1'b1;
                dec.uses_src1 = 1'b1;
                dec.uses_src2 = 1'b1;
            end
            OP_OR: begin
                dec.alu_op    = ALU_OR;
                dec.writes    = 1'b1;
                dec.uses_src1 = 1'b1;
                dec.uses_src2 = 1'b1;
            end
            // Unknown opcodes travel as a NOP that flags itself
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode.sv
// instr_decode: decode (D) and writeback (W) control stage in front of the
// register file; stalls intake on read-after-write hazards against D.
// Ports: clk, reset_n (async, active-low); instr_valid/instr/instr_ready
// intake handshake; rd_addr_a/b, alu_op, use_imm, negate, imm drive the
// ALU from D; alu_result is captured into W; wr_en/wr_addr/wr_data drive
// the register-file write port; illegal_op flags an unknown opcode in D.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [REG_AW-1:0]  rd_addr_a,
    output logic [REG_AW-1:0]  rd_addr_b,
    output logic [2:0]         alu_op,
    output logic               use_imm,
    output logic               negate,
    output logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               wr_en,
    output logic [REG_AW-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               illegal_op
);

    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [DATA_W-1:0] imm;
    } d_reg_t;

    typedef struct packed {
        logic              wr_en;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } w_reg_t;

    d_reg_t d_q, d_d;
    w_reg_t w_q, w_d;

    dec_t in_dec;
    dec_t d_dec;

    logic [OPC_W-1:0]  in_opc;
    logic [REG_AW-1:0] in_dest;
    logic [REG_AW-1:0] in_src1;
    logic [REG_AW-1:0] in_src2;
    logic [DATA_W-1:0] in_imm;

    logic src1_hit;
    logic src2_hit;
    logic hazard;
    logic xfer;
    logic unused_bits;

    assign in_opc  = instr[OPC_LSB  +: OPC_W];
    assign in_dest = instr[DEST_LSB +: REG_AW];
    assign in_src1 = instr[SRC1_LSB +: REG_AW];
    assign in_src2 = instr[SRC2_LSB +: REG_AW];
    assign in_imm  = instr[IMM_LSB  +: DATA_W];

    // Incoming op decoded for the hazard check, D op for the outputs
    opcode_decoder u_dec_in (
        .opcode (in_opc),
        .dec    (in_dec)
    );

    opcode_decoder u_dec_d (
        .opcode (d_q.opcode),
        .dec    (d_dec)
    );

    // Only D can hold an uncommitted result the incoming op could read:
    // W commits on the same edge that the incoming op enters D.
    assign src1_hit = in_dec.uses_src1 && (in_src1 == d_q.dest);
    assign src2_hit = in_dec.uses_src2 && (in_src2 == d_q.dest);
    assign hazard   = d_q.valid && d_dec.writes && (src1_hit || src2_hit);

    // Ready is forced low while reset is asserted
    assign instr_ready = reset_n && !hazard;
    assign xfer        = instr_valid && instr_ready;

    always_comb begin
        d_d = '0;
        if (xfer) begin
            d_d.valid  = 1'b1;
            d_d.opcode = in_opc;
            d_d.dest   = in_dest;
            d_d.src1   = in_src1;
            d_d.src2   = in_src2;
            d_d.imm    = in_imm;
        end
    end

    always_comb begin
        w_d = '0;
        if (d_q.valid && d_dec.writes) begin
            w_d.wr_en = 1'b1;
            w_d.addr  = d_q.dest;
            w_d.data  = alu_result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= '0;
            w_q <= '0;
        end else begin
            d_q <= d_d;
            w_q <= w_d;
        end
    end

    // A bubble in D decodes as opcode 0, so every D output is gated
    always_comb begin
        rd_addr_a  = '0;
        rd_addr_b  = '0;
        alu_op     = ALU_FWD;
        use_imm    = 1'b0;
        negate     = 1'b0;
        imm        = '0;
        illegal_op = 1'b0;
        if (d_q.valid) begin
            rd_addr_a  = d_q.src1;
            rd_addr_b  = d_q.src2;
            alu_op     = d_dec.alu_op;
            use_imm    = d_dec.use_imm;
            negate     = d_dec.negate;
            imm        = d_q.imm;
            illegal_op = d_dec.illegal;
        end
    end

    assign wr_en   = w_q.wr_en;
    assign wr_addr = w_q.addr;
    assign wr_data = w_q.data;

    // Encoding gaps and decode fields not needed on each side
    assign unused_bits = ^{instr[OPC_LSB-1:DEST_LSB+REG_AW],
                           instr[DEST_LSB-1:SRC1_LSB+REG_AW],
                           in_dec.alu_op, in_dec.use_imm,
                           in_dec.negate, in_dec.writes,
                           in_dec.illegal, d_dec.uses_src1,
                           d_dec.uses_src2};

endmodule

// File: doc/instr_decode.md
# instr_decode

Decode-and-writeback control stage for the 8-bit single-issue CPU, sitting directly upstream of the 8×8 register file. It accepts 32-bit instructions over a valid/ready handshake and holds each one in a decode (D) register. From D it drives the register-file read addresses, the ALU controls and the immediate. It captures the ALU result into a writeback (W) register and drives the register-file write port one cycle later, stalling intake on read-after-write hazards.

## Interface
Parameters:
- DATA_W, 8, operand/register width
- REG_AW, 3, register address width (8 registers)
- INSTR_W, 32, instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous reset, active-low
- instr_valid  in  1  instruction offered
- instr  in  INSTR_W  fields: opcode [31:24], dest [18:16], src1 [10:8], src2 [2:0], imm [7:0]
- instr_ready  out  1  stage accepts instr this cycle
- rd_addr_a  out  REG_AW  register-file read address A (src1 of D)
- rd_addr_b  out  REG_AW  register-file read address B (src2 of D)
- alu_op  out  3  000 FWD, 001 ADD, 010 AND, 011 OR
- use_imm  out  1  ALU operand B = imm instead of register B
- negate  out  1  ALU takes two's complement of operand B
- imm  out  DATA_W  immediate of D
- alu_result  in  DATA_W  ALU output, sampled at end of D cycle
- wr_en  out  1  register-file write enable
- wr_addr  out  REG_AW  register-file write address
- wr_data  out  DATA_W  register-file write data
- illegal_op  out  1  one-cycle pulse, unknown opcode left D

## Operation
- Opcodes:
  - 0x00 loadi: FWD, use_imm=1, no sources.
  - 0x01 mov: FWD, source src2.
  - 0x02 add: ADD.
  - 0x03 sub: ADD, negate=1.
  - 0x04 and: AND.
  - 0x05 or: OR.
  - add/sub/and/or read src1 and src2.
- Any other opcode is treated as a NOP: it occupies D, makes no write, and raises illegal_op during the cycle it sits in D.
- Handshake: a transfer occurs when instr_valid && instr_ready at a rising edge. instr must stay stable while valid && !ready.
- D holds {valid, opcode, dest, src1, src2, imm}. It loads on transfer; otherwise it loads a bubble (valid=0).
- When D is valid and the op writes, W loads {wr_en=1, dest, alu_result} at the next edge. Otherwise W loads wr_en=0.
- Hazard: instr_ready=0 when D is valid, D's op writes, and an incoming source used by the incoming op equals D.dest. Sources by op: loadi none, mov src2, ALU ops src1 and src2.
- instr_ready=1 otherwise. No forwarding.
- Arithmetic is modulo 2^DATA_W. Overflow is ignored.
- While D is invalid:
  - alu_op, use_imm, negate, imm and rd_addr_a/b hold 0.
  - illegal_op is 0.

## Timing
- Latency: accept at edge k; instruction in D during cycle k..k+1; wr_en high cycle k+1..k+2; register file commits at edge k+2.
- A dependent instruction offered in the cycle right after its producer's accept sees exactly one cycle with instr_ready=0. It is then accepted, and D reads the committed value.
- Independent instructions sustain one per cycle.
- reset_n low forces immediately, regardless of clk:
  - D.valid=0 and W.wr_en=0.
  - All outputs 0, including instr_ready.
  - An in-flight write is dropped, never committed.
- First acceptance is possible at the first rising edge after reset_n rises.
- instr_valid asserted during reset is ignored.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_LOADI..OP_OR
  - ALU_FWD/ALU_ADD/ALU_AND/ALU_OR
  - field bit-position constants
  - DATA_W/REG_AW defaults
- One combinational sub-module, opcode_decoder: opcode → {alu_op, use_imm, negate, writes, uses_src1, uses_src2, illegal}.
- It is instantiated twice: on incoming instr for the hazard check, and on D for the outputs.
- The D/W registers and the hazard compare live in instr_decode.

## Test plan
- Reset mid-stream: reset_n low while wr_en=1 → wr_en, instr_ready and all outputs 0 immediately, no write committed. Release → instr_ready=1 next cycle.
- loadi r3,35 (0x00030023) accepted at edge 0 → D: alu_op=000, use_imm=1, imm=35. Next cycle: wr_en=1, wr_addr=3, wr_data=35.
- loadi r1,53 then add r2,r1,r3 offered immediately → instr_ready=0 for exactly one cycle. add enters D two edges after loadi; rd_addr_a=1, rd_addr_b=3.
- sub r4,r1,r3 with an ALU model returning 53−35 → alu_op=001, negate=1; wr_addr=4, wr_data=18.
- Opcode 0x06 → illegal_op high one cycle, wr_en stays 0, next instruction accepted without stall.
- loadi r1; loadi r2; add r5,r4,r6 back-to-back → instr_ready constantly 1, wr_en high three consecutive cycles, wr_addr 1, 2, 5.
